img_loader: RTL and testbench
=============================

IMG_LOADER -- requirements
Module: img_loader

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NPIX, 256: pixels per frame; xi width.
- PW, 8: grayscale pixel width.
- THRESH, 128: binarisation threshold.
- NCLS, 10: valid class count.
- TIMEOUT, 4096: max cycles from nn_start rise to nn_done.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- pix_valid, in, 1: pixel present.
- pix_sof, in, 1: pixel is first of a frame.
- pix_data, in, PW: grayscale pixel.
- pix_ready, out, 1: loader accepts a pixel.
- xi, out, NPIX: binarised frame to the classifier.
- nn_start, out, 1: classifier start request.
- nn_ack, in, 1: classifier acknowledges start.
- nn_done, in, 1: classifier result valid.
- nn_yi, in, clog2(NCLS): classifier class index.
- class_valid, out, 1: result available.
- class_id, out, clog2(NCLS): captured class.
- class_err, out, 1: result invalid (timeout or out-of-range index).
- class_ready, in, 1: downstream accepts result.
- busy, out, 1: high in any state other than LOAD.

Function
REQ-003 The FSM SHALL have four states: LOAD, START, WAIT, OUT.
REQ-004 In LOAD, pix_ready SHALL be 1. In every other state it SHALL be 0.
REQ-005 A pixel SHALL be accepted on a cycle with pix_valid=1 and pix_ready=1.
REQ-006 An accepted pixel SHALL write xi[cnt] <= (pix_data >= THRESH), with an unsigned compare, then increment cnt (0..NPIX-1).
REQ-007 An accepted pixel with pix_sof=1 SHALL be written to xi[0] and SHALL set cnt to 1, discarding any partial frame.
REQ-008 Accepting pixel index NPIX-1 SHALL move LOAD->START. nn_start SHALL be 1 on the next cycle, and cnt SHALL return to 0.
REQ-009 In START, nn_start SHALL stay 1 until nn_ack=1 is sampled. nn_start SHALL then be 0 on the next cycle, and the state SHALL move START->WAIT.
REQ-010 In WAIT, nn_done=1 SHALL capture nn_yi into class_id and move WAIT->OUT. class_valid SHALL be 1 on the next cycle.
REQ-011 nn_done asserted while in START SHALL be ignored.
REQ-012 class_err SHALL be set on capture when nn_yi >= NCLS.
REQ-013 A timeout counter SHALL clear on entry to START and increment in START and WAIT.
REQ-014 When the timeout counter reaches TIMEOUT-1 without capture, the state SHALL move to OUT with class_err=1, class_id=0 and nn_start=0.
REQ-015 In OUT, class_valid, class_id and class_err SHALL hold stable until class_valid=1 and class_ready=1 are sampled together.
REQ-016 On that handshake, class_valid and class_err SHALL drop on the next cycle, the state SHALL move OUT->LOAD, and pix_ready SHALL be 1 on that cycle.
REQ-017 xi SHALL hold constant from the START entry until return to LOAD.
REQ-018 xi bits not rewritten in the next frame SHALL retain their old values.
REQ-019 busy SHALL be a registered output equal to (state != LOAD).
REQ-020 nn_start, class_valid and pix_ready SHALL be driven from registers or a state decode with no combinational path from any input.

Reset
REQ-021 When rst=1 is sampled on a clock edge, the next state SHALL be as follows, regardless of the current state (including mid-frame or mid-handshake):
- state=LOAD, cnt=0, timeout counter=0.
- xi=0, nn_start=0, class_valid=0, class_id=0, class_err=0.
- busy=0, pix_ready=1.
REQ-022 Pixels presented during a reset cycle SHALL NOT be accepted.

Verification
REQ-023 Full frame: 256 pixels, even indices 0xFF and odd indices 0x00, pix_valid always 1 -> xi=0x5555...55 and nn_start=1 one cycle after the 256th accept.
REQ-024 Handshake: nn_ack rises 3 cycles after nn_start; nn_done with nn_yi=7 arrives 20 cycles later -> nn_start low 1 cycle after ack; class_valid=1, class_id=7, class_err=0 one cycle after done.
REQ-025 Threshold boundary: pixel values 127, 128, 255, 0 at indices 0..3 -> xi[3:0]=4'b0110.
REQ-026 Mid-frame pix_sof at pixel 100, followed by 255 more pixels -> nn_start fires only after the 256th pixel counted from the sof pixel, and xi[0] equals the sof pixel.
REQ-027 Fault cases -> class_valid=1 and class_err=1 in both cases:
- No nn_done for TIMEOUT cycles -> class_id=0.
- Separately, nn_yi=12 -> class_id=12.
REQ-028 Back-pressure and reset:
- class_ready=0 for 10 cycles -> outputs held stable and pix_ready=0 throughout.
- rst=1 asserted in WAIT -> the next cycle shows all REQ-021 values, and a new frame then loads normally.

Source files
------------

// File: rtl/img_loader.sv
// Grayscale frame loader: binarises a pixel stream into a NPIX-bit vector,
// hands it to a classifier over a start/ack + done handshake, and presents
// the captured class (or an error on timeout / bad index) downstream.
module img_loader #(
    parameter int NPIX    = 256,
    parameter int PW      = 8,
    parameter int THRESH  = 128,
    parameter int NCLS    = 10,
    parameter int TIMEOUT = 4096,
    localparam int YW     = (NCLS > 1) ? $clog2(NCLS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pix_valid,
    input  logic            pix_sof,
    input  logic [PW-1:0]   pix_data,
    output logic            pix_ready,
    output logic [NPIX-1:0] xi,
    output logic            nn_start,
    input  logic            nn_ack,
    input  logic            nn_done,
    input  logic [YW-1:0]   nn_yi,
    output logic            class_valid,
    output logic [YW-1:0]   class_id,
    output logic            class_err,
    input  logic            class_ready,
    output logic            busy
);

    localparam int CW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    // Extra top bit so THRESH = 2**PW (nothing passes) and NCLS = 2**YW still compare correctly.
    localparam logic [PW:0]   THR   = THRESH[PW:0];
    localparam logic [YW:0]   NC    = NCLS[YW:0];
    localparam logic [CW-1:0] LAST  = CW'(NPIX - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {LOAD, START, WAIT, OUT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic          pix_bit;

    assign pix_bit   = ({1'b0, pix_data} >= THR);
    // Pure state decode: no input reaches pix_ready combinationally.
    assign pix_ready = (state == LOAD);

    // Main FSM: pixel loading, classifier handshake, timeout and result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            cnt         <= '0;
            tcnt        <= '0;
            xi          <= '0;
            nn_start    <= 1'b0;
            class_valid <= 1'b0;
            class_id    <= '0;
            class_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (pix_valid) begin
                        if (pix_sof) begin
                            // Restart the frame; stale bits beyond index 0 stay until rewritten.
                            xi[0] <= pix_bit;
                            cnt   <= CW'(1);
                        end else begin
                            xi[cnt] <= pix_bit;
                            if (cnt == LAST) begin
                                cnt      <= '0;
                                tcnt     <= '0;
                                nn_start <= 1'b1;
                                busy     <= 1'b1;
                                state    <= START;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                end
                START: begin
                    tcnt <= tcnt + 1'b1;
                    if (tcnt == TLAST) begin
                        nn_start    <= 1'b0;
                        class_valid <= 1'b1;
                        class_id    <= '0;
                        class_err   <= 1'b1;
                        state       <= OUT;
                    end else if (nn_ack) begin
                        // nn_done is deliberately not looked at until WAIT.
                        nn_start <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    if (nn_done) begin
                        class_valid <= 1'b1;
                        class_id    <= nn_yi;
                        class_err   <= ({1'b0, nn_yi} >= NC);
                        state       <= OUT;
                    end else if (tcnt == TLAST) begin
                        class_valid <= 1'b1;
                        class_id    <= '0;
                        class_err   <= 1'b1;
                        state       <= OUT;
                    end
                end
                OUT: begin
                    // class_valid is always 1 here, so class_ready alone completes the handshake.
                    if (class_ready) begin
                        class_valid <= 1'b0;
                        class_err   <= 1'b0;
                        busy        <= 1'b0;
                        state       <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_img_loader.sv
// Self-checking bench for img_loader: table-driven result scenarios, a
// threshold table, random frames/delays against a frame-level model, and
// hand-written mid-frame sof and reset sequences.
module tb_img_loader;

    localparam int NPIX    = 256;
    localparam int PW      = 8;
    localparam int THRESH  = 128;
    localparam int NCLS    = 10;
    localparam int TIMEOUT = 4096;
    localparam int YW      = $clog2(NCLS);

    logic            clk = 1'b0;
    logic            rst;
    logic            pix_valid, pix_sof;
    logic [PW-1:0]   pix_data;
    logic            pix_ready;
    logic [NPIX-1:0] xi;
    logic            nn_start, nn_ack, nn_done;
    logic [YW-1:0]   nn_yi;
    logic            class_valid, class_err, class_ready, busy;
    logic [YW-1:0]   class_id;

    img_loader #(.NPIX(NPIX), .PW(PW), .THRESH(THRESH), .NCLS(NCLS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data), .pix_ready(pix_ready),
        .xi(xi), .nn_start(nn_start), .nn_ack(nn_ack), .nn_done(nn_done), .nn_yi(nn_yi),
        .class_valid(class_valid), .class_id(class_id), .class_err(class_err),
        .class_ready(class_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;      // 0 alternating FF/00, 1 threshold prefix, 2 random
        int         ack_dly;
        int         done_dly;
        logic [3:0] yi;
        bit         to;        // never ack/done: expect timeout
        bit         dis;       // pulse nn_done while still in START
        int         hold;      // cycles of class_ready=0 in OUT
        logic [3:0] exp_id;
        bit         exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] v;
        logic       b;
    } thr_t;

    vec_t tab[5];
    thr_t thr[6];

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level model: expected xi and write position within the frame.
    logic [NPIX-1:0] mxi;
    int              widx;

    task automatic chk(input string nm, input logic [NPIX-1:0] act, input logic [NPIX-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic send_pix(input logic [7:0] v, input bit sof);
        pix_valid = 1'b1;
        pix_data  = v;
        pix_sof   = sof;
        tick;
        if (sof) widx = 0;
        mxi[widx] = (int'(v) >= THRESH);
        widx++;
        if (widx == NPIX) widx = 0;
    endtask

    task automatic send_frame(input int kind);
        logic [7:0]      v;
        logic [NPIX-1:0] alt;
        for (int i = 0; i < NPIX; i++) begin
            if (kind == 0)                 v = (i % 2 == 0) ? 8'hFF : 8'h00;
            else if (kind == 1 && i < 6)   v = thr[i].v;
            else                           v = 8'($urandom_range(0, 255));
            if (i == NPIX - 1) chk("nn_start before last pixel", nn_start, 1'b0);
            send_pix(v, i == 0);
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        chk("nn_start after last pixel", nn_start, 1'b1);
        chk("busy in START", busy, 1'b1);
        chk("pix_ready in START", pix_ready, 1'b0);
        chk("xi vs model", xi, mxi);
        if (kind == 0) begin
            alt = {(NPIX/2){2'b01}};
            chk("xi alternating", xi, alt);
        end
        if (kind == 1)
            for (int i = 0; i < 6; i++) chk($sformatf("threshold bit %0d", i), xi[i], thr[i].b);
    endtask

    task automatic do_result(input vec_t t);
        logic [NPIX-1:0] snap;
        snap = mxi;
        if (t.to) begin
            for (int k = 0; k < TIMEOUT - 1; k++) tick;
            chk("timeout not yet", class_valid, 1'b0);
            chk("nn_start held to timeout", nn_start, 1'b1);
            tick;
        end else begin
            for (int k = 0; k < t.ack_dly; k++) begin
                if (t.dis && k == 0) begin
                    nn_done = 1'b1;
                    nn_yi   = 4'd3;
                end
                tick;
                nn_done = 1'b0;
            end
            chk("nn_start before ack", nn_start, 1'b1);
            nn_ack = 1'b1;
            tick;
            nn_ack = 1'b0;
            chk("nn_start after ack", nn_start, 1'b0);
            chk("no result yet", class_valid, 1'b0);
            for (int k = 0; k < t.done_dly; k++) tick;
            nn_done = 1'b1;
            nn_yi   = t.yi;
            tick;
            nn_done = 1'b0;
            nn_yi   = 4'($urandom_range(0, 15));
        end
        chk("class_valid", class_valid, 1'b1);
        chk("class_id", class_id, t.exp_id);
        chk("class_err", class_err, t.exp_err);
        chk("nn_start in OUT", nn_start, 1'b0);
        chk("busy in OUT", busy, 1'b1);
        chk("xi held", xi, snap);
        for (int k = 0; k < t.hold; k++) begin
            tick;
            chk("hold class_valid", class_valid, 1'b1);
            chk("hold class_id", class_id, t.exp_id);
            chk("hold class_err", class_err, t.exp_err);
            chk("hold pix_ready", pix_ready, 1'b0);
        end
        class_ready = 1'b1;
        tick;
        class_ready = 1'b0;
        chk("class_valid dropped", class_valid, 1'b0);
        chk("class_err dropped", class_err, 1'b0);
        chk("pix_ready back", pix_ready, 1'b1);
        chk("busy dropped", busy, 1'b0);
    endtask

    initial begin
        vec_t r;

        thr[0] = '{8'd127, 1'b0};
        thr[1] = '{8'd128, 1'b1};
        thr[2] = '{8'd255, 1'b1};
        thr[3] = '{8'd0,   1'b0};
        thr[4] = '{8'd129, 1'b1};
        thr[5] = '{8'd1,   1'b0};

        //           kind ack done yi     to dis hold id     err
        tab[0] = '{0,   3,  20,  4'd7,  0, 0, 10, 4'd7,  0};
        tab[1] = '{1,   1,  0,   4'd12, 0, 0, 0,  4'd12, 1};
        tab[2] = '{2,   2,  5,   4'd9,  0, 1, 2,  4'd9,  0};
        tab[3] = '{2,   0,  0,   4'd0,  1, 0, 1,  4'd0,  1};
        tab[4] = '{2,   0,  0,   4'd15, 0, 0, 0,  4'd15, 1};

        rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
        nn_ack = 1'b0; nn_done = 1'b0; nn_yi = '0; class_ready = 1'b0;
        mxi = '0; widx = 0;
        tick; tick;
        rst = 1'b0;
        chk("reset pix_ready", pix_ready, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset nn_start", nn_start, 1'b0);
        chk("reset class_valid", class_valid, 1'b0);
        chk("reset xi", xi, '0);

        for (int i = 0; i < 5; i++) begin
            send_frame(tab[i].kind);
            do_result(tab[i]);
        end

        // Random frames, delays and class indices.
        for (int i = 0; i < 4; i++) begin
            r.kind     = 2;
            r.ack_dly  = $urandom_range(0, 5);
            r.done_dly = $urandom_range(0, 30);
            r.yi       = 4'($urandom_range(0, 15));
            r.to       = 1'b0;
            r.dis      = 1'b0;
            r.hold     = $urandom_range(0, 3);
            r.exp_id   = r.yi;
            r.exp_err  = (int'(r.yi) >= NCLS);
            send_frame(r.kind);
            do_result(r);
        end

        // Mid-frame sof at pixel 100: frame completes 256 pixels after the sof.
        for (int i = 0; i < 100; i++) send_pix(8'($urandom_range(0, 255)), i == 0);
        send_pix(8'd200, 1'b1);
        for (int i = 1; i < NPIX; i++) begin
            if (i == NPIX - 100) chk("sof discards partial frame", nn_start, 1'b0);
            if (i == NPIX - 1)   chk("sof nn_start before last", nn_start, 1'b0);
            send_pix(8'($urandom_range(0, 255)), 1'b0);
        end
        pix_valid = 1'b0;
        chk("sof nn_start after last", nn_start, 1'b1);
        chk("sof xi[0]", xi[0], 1'b1);
        chk("sof xi vs model", xi, mxi);
        r = '{2, 1, 3, 4'd4, 0, 0, 0, 4'd4, 0};
        do_result(r);

        // Reset while in WAIT, with a pixel offered during the reset cycle.
        send_frame(2);
        nn_ack = 1'b1;
        tick;
        nn_ack = 1'b0;
        tick; tick;
        rst = 1'b1; pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 8'hFF;
        tick;
        rst = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
        chk("rst WAIT pix_ready", pix_ready, 1'b1);
        chk("rst WAIT busy", busy, 1'b0);
        chk("rst WAIT nn_start", nn_start, 1'b0);
        chk("rst WAIT class_valid", class_valid, 1'b0);
        chk("rst WAIT class_id", class_id, '0);
        chk("rst WAIT class_err", class_err, 1'b0);
        chk("rst WAIT xi", xi, '0);
        mxi = '0; widx = 0;
        send_frame(2);
        r = '{2, 2, 4, 4'd5, 0, 0, 1, 4'd5, 0};
        do_result(r);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
